// File: rtl/wr_line_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_line_packer_if
// Description : Word-write and line-write bundle for wr_line_packer.
//               slave  = the packer itself (accepts words, drives lines)
//               master = the surrounding environment (accelerator + channel)
// Revision    : 1.0 - initial release
// ============================================================================
interface wr_line_packer_if #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32
);
  localparam int LINE_WORDS = CACHE_WIDTH / DATA_WIDTH;
  localparam int IDX_W      = $clog2(LINE_WORDS);

  // word side (accelerator -> packer)
  logic [ADDR_LMT+IDX_W-1:0] in_wr_addr;
  logic [MDATA-1:0]          in_wr_mdata;
  logic [DATA_WIDTH-1:0]     in_wr_data;
  logic                      in_wr_en;
  logic                      in_wr_now;
  logic                      in_wr_almostfull;

  // line side (packer -> CCI line-write channel)
  logic [ADDR_LMT-1:0]       ln_wr_addr;
  logic [MDATA-1:0]          ln_wr_mdata;
  logic [CACHE_WIDTH-1:0]    ln_wr_data;
  logic [LINE_WORDS-1:0]     ln_wr_mask;
  logic                      ln_wr_en;
  logic                      ln_wr_almostfull;
  logic                      ln_wr_rsp_valid;

  // status
  logic [7:0]                outstanding;
  logic                      idle;

  modport slave (
    input  in_wr_addr, in_wr_mdata, in_wr_data, in_wr_en, in_wr_now,
    output in_wr_almostfull,
    output ln_wr_addr, ln_wr_mdata, ln_wr_data, ln_wr_mask, ln_wr_en,
    input  ln_wr_almostfull, ln_wr_rsp_valid,
    output outstanding, idle
  );

  modport master (
    output in_wr_addr, in_wr_mdata, in_wr_data, in_wr_en, in_wr_now,
    input  in_wr_almostfull,
    input  ln_wr_addr, ln_wr_mdata, ln_wr_data, ln_wr_mask, ln_wr_en,
    output ln_wr_almostfull, ln_wr_rsp_valid,
    input  outstanding, idle
  );
endinterface
`default_nettype wire

// File: rtl/wr_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : wr_line_packer
// Description : Packs 32-bit result words into 512-bit masked cache lines,
//               queues them in a 4-entry FIFO and issues them to the line
//               write channel while counting outstanding line writes.
//               Optional macro PACKER_TIMEOUT_EN: push a partial line after
//               63 cycles without an accepted word.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_line_packer #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  wr_line_packer_if.slave bus
);
  localparam int LINE_WORDS       = CACHE_WIDTH / DATA_WIDTH;
  localparam int IDX_W            = $clog2(LINE_WORDS);
  localparam int ENT_W            = ADDR_LMT + CACHE_WIDTH + LINE_WORDS + MDATA;
  localparam int FIFO_DEPTH       = 4;
  localparam logic [2:0] FIFO_FULL = 3'd4;
  localparam logic [7:0] OUT_MAX   = 8'hFF;

  // assembly line
  logic                   asm_vld_q,   asm_vld_d;
  logic [ADDR_LMT-1:0]    asm_addr_q,  asm_addr_d;
  logic [CACHE_WIDTH-1:0] asm_data_q,  asm_data_d;
  logic [LINE_WORDS-1:0]  asm_mask_q,  asm_mask_d;
  logic [MDATA-1:0]       asm_mdata_q, asm_mdata_d;
  logic                   flush_pend_q, flush_pend_d;

  // output FIFO and issue register
  logic [ENT_W-1:0]       fifo_q [FIFO_DEPTH];
  logic [1:0]             wr_ptr_q, rd_ptr_q;
  logic [2:0]             cnt_q;
  logic [ENT_W-1:0]       ln_ent_q;
  logic                   ln_en_q;
  logic [7:0]             out_q;

  // combinational helpers
  logic [IDX_W-1:0]       w_idx;
  logic [ADDR_LMT-1:0]    w_laddr;
  logic                   w_same;
  logic [CACHE_WIDTH-1:0] w_mrg_data, w_new_data;
  logic [LINE_WORDS-1:0]  w_mrg_mask, w_new_mask;
  logic                   w_push;
  logic [ADDR_LMT-1:0]    w_push_addr;
  logic [CACHE_WIDTH-1:0] w_push_data;
  logic [LINE_WORDS-1:0]  w_push_mask;
  logic [MDATA-1:0]       w_push_mdata;
  logic [ENT_W-1:0]       w_push_ent;
  logic                   w_can_issue, w_fifo_empty, w_bypass, w_pop, w_issue;
  logic                   w_fifo_wr, w_rsp, w_tmo_fire;

`ifdef PACKER_TIMEOUT_EN
  logic [5:0] tmo_q;

  assign w_tmo_fire = (tmo_q == 6'd63) && asm_vld_q && (cnt_q != FIFO_FULL);

  // Idle timer: restarts on every accepted word, saturates at 63
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          tmo_q <= '0;
    else if (bus.in_wr_en) tmo_q <= '0;
    else if (tmo_q != 6'd63) tmo_q <= tmo_q + 6'd1;
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  assign w_idx   = bus.in_wr_addr[IDX_W-1:0];
  assign w_laddr = bus.in_wr_addr[ADDR_LMT+IDX_W-1:IDX_W];
  assign w_same  = asm_vld_q && (asm_addr_q == w_laddr);

  // Build the merged line (current + word) and a fresh line (word only)
  always_comb begin
    w_mrg_data = asm_vld_q ? asm_data_q : '0;
    w_mrg_mask = asm_vld_q ? asm_mask_q : '0;
    w_mrg_data[w_idx*DATA_WIDTH +: DATA_WIDTH] = bus.in_wr_data;
    w_mrg_mask[w_idx] = 1'b1;
    w_new_data = '0;
    w_new_mask = '0;
    w_new_data[w_idx*DATA_WIDTH +: DATA_WIDTH] = bus.in_wr_data;
    w_new_mask[w_idx] = 1'b1;
  end

  // Assembly next state and the (at most one) line push of this cycle
  always_comb begin
    asm_vld_d    = asm_vld_q;
    asm_addr_d   = asm_addr_q;
    asm_data_d   = asm_data_q;
    asm_mask_d   = asm_mask_q;
    asm_mdata_d  = asm_mdata_q;
    flush_pend_d = 1'b0;
    w_push       = 1'b0;
    w_push_addr  = asm_addr_q;
    w_push_data  = asm_data_q;
    w_push_mask  = asm_mask_q;
    w_push_mdata = asm_mdata_q;
    if (bus.in_wr_en) begin
      if (asm_vld_q && !w_same) begin
        // leaving the line: retire the old one, open a new one with this word
        w_push       = 1'b1;
        asm_vld_d    = 1'b1;
        asm_addr_d   = w_laddr;
        asm_data_d   = w_new_data;
        asm_mask_d   = w_new_mask;
        asm_mdata_d  = bus.in_wr_mdata;
        flush_pend_d = bus.in_wr_now;
      end else begin
        w_push_addr  = w_laddr;
        w_push_data  = w_mrg_data;
        w_push_mask  = w_mrg_mask;
        w_push_mdata = bus.in_wr_mdata;
        // a pending flush also retires the line the word merged into
        if ((&w_mrg_mask) || bus.in_wr_now || flush_pend_q) begin
          w_push    = 1'b1;
          asm_vld_d = 1'b0;
        end else begin
          asm_vld_d   = 1'b1;
          asm_addr_d  = w_laddr;
          asm_data_d  = w_mrg_data;
          asm_mask_d  = w_mrg_mask;
          asm_mdata_d = bus.in_wr_mdata;
        end
      end
    end else if ((flush_pend_q || w_tmo_fire) && asm_vld_q) begin
      w_push    = 1'b1;
      asm_vld_d = 1'b0;
    end
  end

  assign w_push_ent   = {w_push_addr, w_push_data, w_push_mask, w_push_mdata};
  assign w_can_issue  = !bus.ln_wr_almostfull && (out_q != OUT_MAX);
  assign w_fifo_empty = (cnt_q == 3'd0);
  // an empty FIFO lets a fresh push go straight to the issue register
  assign w_bypass     = w_push && w_fifo_empty && w_can_issue;
  assign w_pop        = !w_fifo_empty && w_can_issue;
  assign w_issue      = w_pop || w_bypass;
  assign w_fifo_wr    = w_push && !w_bypass && ((cnt_q != FIFO_FULL) || w_pop);
  assign w_rsp        = bus.ln_wr_rsp_valid && (out_q != 8'd0);

  // Assembly line registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_vld_q    <= 1'b0;
      asm_addr_q   <= '0;
      asm_data_q   <= '0;
      asm_mask_q   <= '0;
      asm_mdata_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      asm_vld_q    <= asm_vld_d;
      asm_addr_q   <= asm_addr_d;
      asm_data_q   <= asm_data_d;
      asm_mask_q   <= asm_mask_d;
      asm_mdata_q  <= asm_mdata_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // FIFO storage; validity is carried by the pointers and count
  always_ff @(posedge clk) begin
    if (w_fifo_wr) fifo_q[wr_ptr_q] <= w_push_ent;
  end

  // FIFO pointers, line issue register and outstanding counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ln_ent_q <= '0;
      ln_en_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      if (w_fifo_wr) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (w_pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      cnt_q   <= cnt_q + {2'b00, w_fifo_wr} - {2'b00, w_pop};
      ln_en_q <= w_issue;
      if (w_pop)         ln_ent_q <= fifo_q[rd_ptr_q];
      else if (w_bypass) ln_ent_q <= w_push_ent;
      if (w_issue && !w_rsp)      out_q <= out_q + 8'd1;
      else if (!w_issue && w_rsp) out_q <= out_q - 8'd1;
    end
  end

  assign bus.ln_wr_mdata      = ln_ent_q[MDATA-1:0];
  assign bus.ln_wr_mask       = ln_ent_q[MDATA +: LINE_WORDS];
  assign bus.ln_wr_data       = ln_ent_q[MDATA+LINE_WORDS +: CACHE_WIDTH];
  assign bus.ln_wr_addr       = ln_ent_q[MDATA+LINE_WORDS+CACHE_WIDTH +: ADDR_LMT];
  assign bus.ln_wr_en         = ln_en_q;
  assign bus.outstanding      = out_q;
  // two entries of headroom absorb the upstream one-cycle reaction lag
  assign bus.in_wr_almostfull = (cnt_q >= 3'd2) || flush_pend_q;
  assign bus.idle             = !asm_vld_q && w_fifo_empty && !flush_pend_q &&
                                (out_q == 8'd0);
endmodule
`default_nettype wire
